// File: rtl/seg_code_scan.sv
// Debounces encoder code/valid, keeps a four-deep history of distinct commits,
// and scans the history onto a 4-digit active-low seven-segment display.
module seg_code_scan #(
  parameter int STABLE_CYCLES = 4,
  parameter int SCAN_DIV      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] code,
  input  logic       code_vld,
  input  logic       en,
  input  logic       clr,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       commit,
  output logic [2:0] last,
  output logic [2:0] fill
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SMAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] SPRE = CW'(STABLE_CYCLES - 1);
  localparam logic [DW-1:0] DMAX = DW'(SCAN_DIV - 1);

  logic [4:0]       s;
  logic [4:0]       prev;
  logic [CW-1:0]    stab_cnt;
  logic [3:0][2:0]  hist;
  logic [DW-1:0]    div;
  logic [1:0]       idx;
  logic             dup;
  logic             hit;

  assign s    = {en, code_vld, code};
  assign dup  = (fill != 3'd0) && (prev[2:0] == hist[0]);
  // Only the edge that completes the stable window can commit.
  assign hit  = (s == prev) && (stab_cnt == SPRE)
              && prev[4] && prev[3] && !dup;
  assign last = hist[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= '0;
      stab_cnt <= '0;
      hist     <= '0;
      fill     <= '0;
      commit   <= 1'b0;
      div      <= '0;
      idx      <= '0;
    end else begin
      if (s != prev) begin
        prev     <= s;
        stab_cnt <= '0;
      end else if (stab_cnt < SMAX) begin
        stab_cnt <= stab_cnt + 1'b1;
      end

      if (clr) begin
        hist   <= '0;
        fill   <= '0;
        commit <= 1'b0;
      end else if (hit) begin
        hist   <= {hist[2:0], prev[2:0]};
        fill   <= (fill == 3'd4) ? fill : fill + 3'd1;
        commit <= 1'b1;
      end else begin
        commit <= 1'b0;
      end

      if (div == DMAX) begin
        div <= '0;
        idx <= idx + 2'd1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  function automatic logic [7:0] decode(input logic [2:0] c);
    logic [7:0] r;
    unique case (c)
      3'd0: r = 8'hC0;
      3'd1: r = 8'hF9;
      3'd2: r = 8'hA4;
      3'd3: r = 8'hB0;
      3'd4: r = 8'h99;
      3'd5: r = 8'h92;
      3'd6: r = 8'h82;
      3'd7: r = 8'hF8;
    endcase
    return r;
  endfunction

  always_comb begin
    an  = 4'b1111;
    seg = 8'hFF;
    if (en) begin
      an = ~(4'b0001 << idx);
      if ({1'b0, idx} < fill)
        seg = decode(hist[idx]);
    end
  end

endmodule

// File: tb/tb_seg_code_scan.sv
// Randomized and directed bench for seg_code_scan against a run-length
// history model.
module tb_seg_code_scan;

  localparam int SC = 4;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] code = '0;
  logic       code_vld = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] seg;
  logic [3:0] an;
  logic       commit;
  logic [2:0] last;
  logic [2:0] fill;

  int checks = 0;
  int failures = 0;

  // Model: history as a queue (front = newest), run length of the input.
  int         m_hist[$];
  bit         m_commit;
  logic [4:0] run_val;
  int         run_len;
  int         cyc;

  seg_code_scan #(.STABLE_CYCLES(SC), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .code(code), .code_vld(code_vld),
    .en(en), .clr(clr), .seg(seg), .an(an), .commit(commit),
    .last(last), .fill(fill)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dec7(input int c);
    case (c)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      default: return 8'hF8;
    endcase
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0] a;
    int k;
    if (!en) return 4'b1111;
    k = (cyc / SD) % 4;
    a = 4'b0001 << k;
    return ~a;
  endfunction

  function automatic logic [7:0] exp_seg();
    int k;
    if (!en) return 8'hFF;
    k = (cyc / SD) % 4;
    if (k < m_hist.size()) return dec7(m_hist[k]);
    return 8'hFF;
  endfunction

  function automatic logic [2:0] exp_last();
    if (m_hist.size() > 0) return 3'(m_hist[0]);
    return 3'd0;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_commit = 1'b0;
    run_val  = '0;
    run_len  = 1;
    cyc      = 0;
  endtask

  task automatic tick();
    logic [4:0] s;
    @(posedge clk);
    if (rst_n) begin
      s = {en, code_vld, code};
      if (s == run_val) run_len++;
      else begin
        run_val = s;
        run_len = 1;
      end
      m_commit = 1'b0;
      if (run_len == SC + 1 && run_val[4] && run_val[3] &&
          !(m_hist.size() > 0 && m_hist[0] == int'(run_val[2:0]))) begin
        m_commit = 1'b1;
        m_hist.push_front(int'(run_val[2:0]));
        if (m_hist.size() > 4) void'(m_hist.pop_back());
      end
      if (clr) begin
        m_hist.delete();
        m_commit = 1'b0;
      end
      cyc++;
    end
    #1;
  endtask

  task automatic test_reset();
    en = 1'b1;
    #1;
    checks++;
    if (an !== 4'b1110 || seg !== 8'hFF) begin
      failures++;
      $display("FAIL reset_disp an=%b seg=%h exp an=1110 seg=ff", an, seg);
    end
    checks++;
    if (commit !== 1'b0 || last !== 3'd0 || fill !== 3'd0) begin
      failures++;
      $display("FAIL reset_regs commit=%b last=%0d fill=%0d exp 0/0/0",
               commit, last, fill);
    end
    en = 1'b0;
    #1;
    checks++;
    if (an !== 4'b1111) begin
      failures++;
      $display("FAIL reset_an_off an=%b exp 1111", an);
    end
  endtask

  task automatic test_first_commit();
    int edge_at = -1;
    en = 1'b1; code = 3'd5; code_vld = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (commit === 1'b1 && edge_at < 0) edge_at = i;
      checks++;
      if (commit !== m_commit) begin
        failures++;
        $display("FAIL first_commit edge=%0d commit=%b exp=%b", i, commit, m_commit);
      end
    end
    checks++;
    if (edge_at !== 5 || last !== 3'd5 || fill !== 3'd1) begin
      failures++;
      $display("FAIL first_latency edge=%0d last=%0d fill=%0d exp 5/5/1",
               edge_at, last, fill);
    end
    for (int i = 0; i < 4 * SD; i++) begin
      tick();
      checks++;
      if (an !== exp_an() || seg !== exp_seg()) begin
        failures++;
        $display("FAIL first_scan an=%b seg=%h exp an=%b seg=%h",
                 an, seg, exp_an(), exp_seg());
      end
    end
  endtask

  task automatic test_sequence();
    int codes[5] = '{1, 2, 3, 4, 6};
    int n = 0;
    foreach (codes[j]) begin
      code = 3'(codes[j]);
      repeat (8) begin
        tick();
        if (commit === 1'b1) n++;
        checks++;
        if (commit !== m_commit) begin
          failures++;
          $display("FAIL seq_commit code=%0d commit=%b exp=%b", codes[j], commit, m_commit);
        end
      end
    end
    checks++;
    if (n !== 5 || fill !== 3'd4 || last !== 3'd6) begin
      failures++;
      $display("FAIL seq_fill commits=%0d fill=%0d last=%0d exp 5/4/6", n, fill, last);
    end
    for (int i = 0; i < 4 * SD; i++) begin
      tick();
      checks++;
      if (an !== exp_an() || seg !== exp_seg()) begin
        failures++;
        $display("FAIL seq_scan an=%b seg=%h exp an=%b seg=%h",
                 an, seg, exp_an(), exp_seg());
      end
    end
  endtask

  task automatic test_glitch();
    int n = 0;
    code = 3'd3;
    repeat (8) tick();
    checks++;
    if (last !== 3'd3) begin
      failures++;
      $display("FAIL glitch_base last=%0d exp 3", last);
    end
    code = 3'd7;
    repeat (3) begin
      tick();
      if (commit === 1'b1) n++;
    end
    code = 3'd3;
    repeat (10) begin
      tick();
      if (commit === 1'b1) n++;
    end
    checks++;
    if (n !== 0 || last !== 3'd3) begin
      failures++;
      $display("FAIL glitch_dup commits=%0d last=%0d exp 0/3", n, last);
    end
  endtask

  task automatic test_enable();
    int n = 0;
    en = 1'b0; code = 3'd2; code_vld = 1'b1;
    repeat (10) begin
      tick();
      if (commit === 1'b1) n++;
      checks++;
      if (an !== 4'b1111 || seg !== 8'hFF) begin
        failures++;
        $display("FAIL en_off_disp an=%b seg=%h exp 1111/ff", an, seg);
      end
    end
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL en_off_commit commits=%0d exp 0", n);
    end
    en = 1'b1; code = 3'd5;
    repeat (10) begin
      tick();
      if (commit === 1'b1) n++;
    end
    checks++;
    if (n !== 1 || last !== 3'd5 || fill !== 3'd4) begin
      failures++;
      $display("FAIL en_on commits=%0d last=%0d fill=%0d exp 1/5/4", n, last, fill);
    end
  endtask

  task automatic test_clr();
    code = 3'd1;
    for (int i = 0; i < 20 && run_len != SC; i++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (commit !== 1'b0 || fill !== 3'd0 || last !== 3'd0) begin
      failures++;
      $display("FAIL clr_edge commit=%b fill=%0d last=%0d exp 0/0/0",
               commit, fill, last);
    end
    repeat (10) begin
      tick();
      checks++;
      if (commit !== 1'b0 || seg !== 8'hFF || an !== exp_an()) begin
        failures++;
        $display("FAIL clr_hold commit=%b seg=%h an=%b exp 0/ff/%b",
                 commit, seg, an, exp_an());
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    repeat (400) begin
      if (hold == 0) begin
        code     = 3'($urandom_range(0, 7));
        code_vld = ($urandom_range(0, 5) != 0);
        en       = ($urandom_range(0, 7) != 0);
        hold     = $urandom_range(1, 9);
      end
      hold--;
      clr = ($urandom_range(0, 39) == 0);
      tick();
      checks++;
      if (commit !== m_commit || last !== exp_last() ||
          fill !== 3'(m_hist.size()) || an !== exp_an() || seg !== exp_seg()) begin
        failures++;
        $display("FAIL random c=%b l=%0d f=%0d an=%b seg=%h exp c=%b l=%0d f=%0d an=%b seg=%h",
                 commit, last, fill, an, seg, m_commit, exp_last(),
                 m_hist.size(), exp_an(), exp_seg());
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    int edge_at = -1;
    en = 1'b1; code_vld = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      code = 3'(c);
      repeat (7) tick();
    end
    checks++;
    if (fill !== 3'd3) begin
      failures++;
      $display("FAIL mid_fill fill=%0d exp 3", fill);
    end
    repeat (6) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (commit !== 1'b0 || last !== 3'd0 || fill !== 3'd0 ||
        seg !== 8'hFF || an !== 4'b1110) begin
      failures++;
      $display("FAIL mid_reset c=%b l=%0d f=%0d seg=%h an=%b exp 0/0/0/ff/1110",
               commit, last, fill, seg, an);
    end
    @(negedge clk);
    rst_n = 1'b1;
    code = 3'd4;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (commit === 1'b1 && edge_at < 0) edge_at = i;
    end
    checks++;
    if (edge_at !== 5 || last !== 3'd4 || fill !== 3'd1) begin
      failures++;
      $display("FAIL mid_recommit edge=%0d last=%0d fill=%0d exp 5/4/1",
               edge_at, last, fill);
    end
  endtask

  initial begin
    model_reset();
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_first_commit();
    test_sequence();
    test_glitch();
    test_enable();
    test_clr();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_code_scan.md
# seg_code_scan

Downstream consumer of the 8-to-3 switch encoder. Debounces the encoder's 3-bit code and committed-valid flag, records the last four distinct committed codes in a history buffer, and drives a time-multiplexed 4-digit active-low seven-segment display, newest code on digit 0. Sits between the encoder output and the board display pins.

## Interface
- STABLE_CYCLES, 4: consecutive clock edges an input must stay unchanged before commit (≥1).
- SCAN_DIV, 16: clock cycles each digit stays selected (≥2).

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- code  in  3  encoder output y.
- code_vld  in  1  high when any switch is on (OR of encoder input x).
- en  in  1  encoder enable; also display enable.
- clr  in  1  synchronous history clear, active-high.
- seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- an  out  4  digit select, active-low, one-hot-zero.
- commit  out  1  one-cycle pulse when a code enters history.
- last  out  3  newest committed code (hist[0]).
- fill  out  3  number of valid history entries, 0..4.

## Operation
- Input tuple s = {en, code_vld, code}, 5 bits. Register prev holds last sampled s; stab_cnt counts edges with s == prev.
- Each edge: if s != prev: prev <= s, stab_cnt <= 0. Else if stab_cnt < STABLE_CYCLES: stab_cnt <= stab_cnt + 1; saturates at STABLE_CYCLES.
- Commit condition: at the edge where stab_cnt goes STABLE_CYCLES-1 -> STABLE_CYCLES, with prev.en = 1, prev.code_vld = 1, and NOT (fill > 0 and prev.code == hist[0]). Fires at most once per stable period.
- On commit: hist[3..1] <= hist[2..0], hist[0] <= prev.code, fill <= min(fill+1, 4), commit <= 1 for one cycle; else commit <= 0.
- clr = 1: hist all 0, fill <= 0, commit <= 0; clr wins over a same-edge commit. stab_cnt/prev unaffected (no re-commit of an already-saturated input).
- Duplicate code (equal to hist[0]) never commits; same code after an intervening different commit does.
- Scan: div counts 0..SCAN_DIV-1, wraps; on wrap idx <= idx+1 mod 4.
- Display (combinational from registers and en): en = 0 -> an = 4'b1111, seg = 8'hFF. en = 1 -> an = ~(4'b0001 << idx); seg = decode(hist[idx]) if idx < fill else 8'hFF (blank).
- decode: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8; dp always off.

## Timing
- Reset (rst_n low, immediate): prev 0, stab_cnt 0, hist 0, fill 0, commit 0, div 0, idx 0; hence last = 0, fill = 0, seg = 8'hFF, an = 4'b1110 if en else 4'b1111.
- Commit latency: new s sampled at edge E0; commit at edge E(STABLE_CYCLES); commit high during the cycle after that edge; last/fill/seg update at that same edge.
- Any change of s before E(STABLE_CYCLES) restarts the count; glitches shorter than STABLE_CYCLES+1 edges never commit.
- Digit period SCAN_DIV cycles; full frame 4*SCAN_DIV cycles. Reset mid-scan returns to digit 0, div 0.
- No handshake; commit is informational, no backpressure.

## Test plan
- STABLE_CYCLES=4, SCAN_DIV=4. Reset, en=1, code=5, code_vld=1 held -> commit pulse exactly once, 5 edges after first sample; last=5, fill=1; digit 0 shows 8'h92, digits 1-3 blank.
- Apply codes 1,2,3,4,6 each held 8 cycles -> 5 commits, fill saturates at 4; hist = 6,4,3,2; an sequence 1110,1101,1011,0111 each 4 cycles showing 82,99,B0,A4.
- Code 3 held, changed to 7 for 3 cycles, back to 3 -> no commit for 7; 3 not re-committed (duplicate); commit count unchanged.
- en=0 with code_vld=1 stable 10 cycles -> no commit, an=1111, seg=FF; en back to 1 with new stable code -> commits, history intact.
- clr asserted on the commit edge -> fill=0, commit=0, all digits blank; held code does not re-commit until input changes.
- Assert rst_n low mid-frame with fill=3 -> all outputs to reset values asynchronously; after release, first commit again after 5 edges.
